// File: rtl/lane_queue_sensor.sv
// Purpose: conditions raw loop-detector pulses for four lanes, tracks each lane's queue and drives S1/S5/flags.
// Latency: DEBOUNCE+2 clk edges from the first sampling edge of a clean raw rise to the q/S1/S5 update.
// Backpressure: none; each lane takes at most one arrival and one departure event per cycle and never stalls.

// One detector channel: two-flop synchronizer, stability-counter debouncer and
// rising-edge detector. Emits a single-cycle event per accepted rising level.
module lqs_det_chan #(
    parameter int DEBOUNCE = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic i_raw,
    output logic o_evt
);

    // Counter only needs to reach DEBOUNCE-1: the flip happens on the edge that
    // would make it DEBOUNCE, so the counter is cleared instead of stored.
    localparam int CW = (DEBOUNCE < 2) ? 1 : $clog2(DEBOUNCE);
    localparam logic [CW-1:0] CNT_TOP = CW'(DEBOUNCE - 1);

    logic          r_sync1;
    logic          r_sync2;
    logic          r_deb;
    logic          r_deb_d;
    logic [CW-1:0] r_cnt;

    // Bring the asynchronous detector level into the clk domain.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
        end else begin
            r_sync1 <= i_raw;
            r_sync2 <= r_sync1;
        end
    end

    // Accept a new level only after DEBOUNCE consecutive disagreeing samples.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_deb <= 1'b0;
            r_cnt <= '0;
        end else if (r_sync2 == r_deb) begin
            r_cnt <= '0;
        end else if (r_cnt == CNT_TOP) begin
            r_deb <= r_sync2;
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + CW'(1);
        end
    end

    // Delayed copy of the debounced level for rising-edge detection.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_deb_d <= 1'b0;
        end else begin
            r_deb_d <= r_deb;
        end
    end

    // Event is high for exactly the one cycle after the debounced level rises;
    // it only feeds registered lane state, never a module output directly.
    assign o_evt = r_deb & ~r_deb_d;

endmodule

// One lane: saturating queue counter, departure qualification against the
// lane's own light, S1/S5 generation with hysteresis and sticky error flags.
module lqs_lane #(
    parameter int QW          = 6,
    parameter int CONG_THRESH = 8,
    parameter int HYST        = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_arr,
    input  logic          i_dep,
    input  logic [1:0]    i_light,
    input  logic          i_err_clr,
    output logic [QW-1:0] o_q,
    output logic          o_s1,
    output logic          o_s5,
    output logic          o_ovf,
    output logic          o_red
);

    localparam logic [QW-1:0] Q_MAX = '1;
    localparam logic [QW-1:0] Q_SET = QW'(CONG_THRESH);
    localparam logic [QW-1:0] Q_CLR = QW'(CONG_THRESH - HYST);

    logic [QW-1:0] r_q;
    logic          r_s1;
    logic          r_s5;
    logic          r_ovf;
    logic          r_red;

    logic          w_go;
    logic          w_dep_ok;
    logic          w_red_set;
    logic          w_ovf_set;
    logic [QW-1:0] w_q_nxt;
    logic          w_s5_nxt;

    // Next queue value, flag set conditions and S5 hysteresis decision.
    always_comb begin
        w_go      = (i_light == 2'b01) || (i_light == 2'b10);
        w_dep_ok  = i_dep & w_go;
        w_red_set = i_dep & ~w_go;
        w_ovf_set = 1'b0;
        w_q_nxt   = r_q;
        w_s5_nxt  = r_s5;

        // Arrival and counted departure together cancel, even at the rails.
        if (i_arr && !w_dep_ok) begin
            if (r_q == Q_MAX) begin
                w_ovf_set = 1'b1;
            end else begin
                w_q_nxt = r_q + QW'(1);
            end
        end else if (w_dep_ok && !i_arr) begin
            if (r_q != '0) begin
                w_q_nxt = r_q - QW'(1);
            end
        end

        if (w_q_nxt >= Q_SET) begin
            w_s5_nxt = 1'b1;
        end else if (w_q_nxt < Q_CLR) begin
            w_s5_nxt = 1'b0;
        end
    end

    // Queue count and the sensor outputs derived from the next count.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_q  <= '0;
            r_s1 <= 1'b0;
            r_s5 <= 1'b0;
        end else begin
            r_q  <= w_q_nxt;
            r_s1 <= (w_q_nxt != '0);
            r_s5 <= w_s5_nxt;
        end
    end

    // Sticky flags: a set in the same cycle as a clear wins.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_ovf <= 1'b0;
            r_red <= 1'b0;
        end else begin
            r_ovf <= (r_ovf & ~i_err_clr) | w_ovf_set;
            r_red <= (r_red & ~i_err_clr) | w_red_set;
        end
    end

    assign o_q   = r_q;
    assign o_s1  = r_s1;
    assign o_s5  = r_s5;
    assign o_ovf = r_ovf;
    assign o_red = r_red;

endmodule

// Top: eight detector channels feeding four independent lanes.
module lane_queue_sensor #(
    parameter int DEBOUNCE    = 4,
    parameter int QW          = 6,
    parameter int CONG_THRESH = 8,
    parameter int HYST        = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          arr_NS,
    input  logic          arr_SN,
    input  logic          arr_EW,
    input  logic          arr_WE,
    input  logic          dep_NS,
    input  logic          dep_SN,
    input  logic          dep_EW,
    input  logic          dep_WE,
    input  logic [1:0]    NS_light,
    input  logic [1:0]    SN_light,
    input  logic [1:0]    EW_light,
    input  logic [1:0]    WE_light,
    input  logic          err_clr,
    output logic          S1_NS,
    output logic          S1_SN,
    output logic          S1_EW,
    output logic          S1_WE,
    output logic          S5_NS,
    output logic          S5_SN,
    output logic          S5_EW,
    output logic          S5_WE,
    output logic [QW-1:0] q_NS,
    output logic [QW-1:0] q_SN,
    output logic [QW-1:0] q_EW,
    output logic [QW-1:0] q_WE,
    output logic [3:0]    ovf,
    output logic [3:0]    red_run
);

    // Channels 0..3 are arrivals, 4..7 departures; lane order NS, SN, EW, WE.
    logic [7:0]    w_raw;
    logic [7:0]    w_evt;
    logic [1:0]    w_light [4];
    logic [QW-1:0] w_q     [4];
    logic [3:0]    w_s1;
    logic [3:0]    w_s5;
    logic [3:0]    w_ovf;
    logic [3:0]    w_red;

    assign w_raw = {dep_WE, dep_EW, dep_SN, dep_NS, arr_WE, arr_EW, arr_SN, arr_NS};

    assign w_light[0] = NS_light;
    assign w_light[1] = SN_light;
    assign w_light[2] = EW_light;
    assign w_light[3] = WE_light;

    for (genvar g_ch = 0; g_ch < 8; g_ch++) begin : g_chan
        lqs_det_chan #(
            .DEBOUNCE (DEBOUNCE)
        ) u_chan (
            .clk   (clk),
            .rst   (rst),
            .i_raw (w_raw[g_ch]),
            .o_evt (w_evt[g_ch])
        );
    end

    for (genvar g_ln = 0; g_ln < 4; g_ln++) begin : g_lane
        lqs_lane #(
            .QW          (QW),
            .CONG_THRESH (CONG_THRESH),
            .HYST        (HYST)
        ) u_lane (
            .clk       (clk),
            .rst       (rst),
            .i_arr     (w_evt[g_ln]),
            .i_dep     (w_evt[4 + g_ln]),
            .i_light   (w_light[g_ln]),
            .i_err_clr (err_clr),
            .o_q       (w_q[g_ln]),
            .o_s1      (w_s1[g_ln]),
            .o_s5      (w_s5[g_ln]),
            .o_ovf     (w_ovf[g_ln]),
            .o_red     (w_red[g_ln])
        );
    end

    assign q_NS    = w_q[0];
    assign q_SN    = w_q[1];
    assign q_EW    = w_q[2];
    assign q_WE    = w_q[3];
    assign S1_NS   = w_s1[0];
    assign S1_SN   = w_s1[1];
    assign S1_EW   = w_s1[2];
    assign S1_WE   = w_s1[3];
    assign S5_NS   = w_s5[0];
    assign S5_SN   = w_s5[1];
    assign S5_EW   = w_s5[2];
    assign S5_WE   = w_s5[3];
    assign ovf     = w_ovf;
    assign red_run = w_red;

endmodule

// File: tb/tb_lane_queue_sensor.sv
// Bench for lane_queue_sensor: directed vector table, hand-written corner sequences
// and a randomized run against a queue-arithmetic reference model.
module tb_lane_queue_sensor;

    localparam int DEBOUNCE    = 4;
    localparam int QW          = 6;
    localparam int CONG_THRESH = 8;
    localparam int HYST        = 2;
    localparam int QMAX        = (1 << QW) - 1;
    localparam int NCYC        = 3000;
    localparam int LAT         = DEBOUNCE + 2;

    logic          clk = 1'b0;
    logic          rst;
    logic [7:0]    raw;
    logic [1:0]    light [4];
    logic          err_clr;
    logic          S1_NS, S1_SN, S1_EW, S1_WE;
    logic          S5_NS, S5_SN, S5_EW, S5_WE;
    logic [QW-1:0] q_NS, q_SN, q_EW, q_WE;
    logic [3:0]    ovf, red_run;

    logic [QW-1:0] q_v [4];
    logic [3:0]    s1_v, s5_v;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    lane_queue_sensor #(
        .DEBOUNCE(DEBOUNCE), .QW(QW), .CONG_THRESH(CONG_THRESH), .HYST(HYST)
    ) dut (
        .clk(clk), .rst(rst),
        .arr_NS(raw[0]), .arr_SN(raw[1]), .arr_EW(raw[2]), .arr_WE(raw[3]),
        .dep_NS(raw[4]), .dep_SN(raw[5]), .dep_EW(raw[6]), .dep_WE(raw[7]),
        .NS_light(light[0]), .SN_light(light[1]), .EW_light(light[2]), .WE_light(light[3]),
        .err_clr(err_clr),
        .S1_NS(S1_NS), .S1_SN(S1_SN), .S1_EW(S1_EW), .S1_WE(S1_WE),
        .S5_NS(S5_NS), .S5_SN(S5_SN), .S5_EW(S5_EW), .S5_WE(S5_WE),
        .q_NS(q_NS), .q_SN(q_SN), .q_EW(q_EW), .q_WE(q_WE),
        .ovf(ovf), .red_run(red_run)
    );

    assign q_v[0] = q_NS;
    assign q_v[1] = q_SN;
    assign q_v[2] = q_EW;
    assign q_v[3] = q_WE;
    assign s1_v   = {S1_WE, S1_EW, S1_SN, S1_NS};
    assign s5_v   = {S5_WE, S5_EW, S5_SN, S5_NS};

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [39:0] dut_vec();
        return {q_WE, q_EW, q_SN, q_NS, s1_v, s5_v, ovf, red_run};
    endfunction

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b0;
        raw = '0;
        err_clr = 1'b0;
        for (int l = 0; l < 4; l++) light[l] = 2'b00;
        tick(3);
        rst = 1'b1;
        tick(2);
    endtask

    task automatic pulse(input int ch, input int hi, input int lo);
        raw[ch] = 1'b1;
        tick(hi);
        raw[ch] = 1'b0;
        tick(lo);
    endtask

    typedef struct {
        int       lane;
        int       n_arr;
        int       n_dep;
        logic [1:0] lt;
        int       exp_q;
        bit       exp_s1;
        bit       exp_s5;
        bit       exp_red;
        bit       exp_ovf;
    } vec_t;

    vec_t tbl [11];

    // Reference model state for the randomized run.
    bit   ev [8][NCYC + 16];
    int   mq [4];
    bit   ms1 [4];
    bit   ms5 [4];
    logic [3:0] movf, mred, ovf_set, red_set;
    int   seg_left [8];
    bit   lvl [8];
    logic [39:0] mvec;

    function automatic logic [39:0] model_vec();
        logic [3:0] b1, b5;
        for (int l = 0; l < 4; l++) begin
            b1[l] = ms1[l];
            b5[l] = ms5[l];
        end
        return {QW'(mq[3]), QW'(mq[2]), QW'(mq[1]), QW'(mq[0]), b1, b5, movf, mred};
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit a, d, go;
        int r, gmax;

        rst = 1'b0;
        raw = '0;
        err_clr = 1'b0;
        for (int l = 0; l < 4; l++) light[l] = 2'b00;
        tick(3);
        chk("reset_state", 64'(dut_vec()), 64'd0);
        rst = 1'b1;
        tick(2);

        // lane, arrivals, departures, light -> q, S1, S5, red_run bit, ovf bit
        tbl[0]  = '{0, 3, 0, 2'b10, 3, 1, 0, 0, 0};
        tbl[1]  = '{1, 2, 1, 2'b01, 1, 1, 0, 0, 0};
        tbl[2]  = '{2, 1, 2, 2'b10, 0, 0, 0, 0, 0};
        tbl[3]  = '{3, 3, 1, 2'b00, 3, 1, 0, 1, 0};
        tbl[4]  = '{1, 2, 1, 2'b11, 2, 1, 0, 1, 0};
        tbl[5]  = '{2, 8, 0, 2'b10, 8, 1, 1, 0, 0};
        tbl[6]  = '{2, 8, 1, 2'b10, 7, 1, 1, 0, 0};
        tbl[7]  = '{2, 8, 2, 2'b10, 6, 1, 1, 0, 0};
        tbl[8]  = '{2, 8, 3, 2'b10, 5, 1, 0, 0, 0};
        tbl[9]  = '{0, 7, 0, 2'b10, 7, 1, 0, 0, 0};
        tbl[10] = '{3, 0, 2, 2'b01, 0, 0, 0, 0, 0};

        for (int i = 0; i < 11; i++) begin
            do_reset();
            light[tbl[i].lane] = tbl[i].lt;
            repeat (tbl[i].n_arr) pulse(tbl[i].lane, 5, 5);
            repeat (tbl[i].n_dep) pulse(4 + tbl[i].lane, 5, 5);
            tick(8);
            chk($sformatf("tbl%0d_q", i),   64'(q_v[tbl[i].lane]), 64'(tbl[i].exp_q));
            chk($sformatf("tbl%0d_s1", i),  64'(s1_v), 64'(tbl[i].exp_s1) << tbl[i].lane);
            chk($sformatf("tbl%0d_s5", i),  64'(s5_v), 64'(tbl[i].exp_s5) << tbl[i].lane);
            chk($sformatf("tbl%0d_red", i), 64'(red_run), 64'(tbl[i].exp_red) << tbl[i].lane);
            chk($sformatf("tbl%0d_ovf", i), 64'(ovf), 64'(tbl[i].exp_ovf) << tbl[i].lane);
        end

        // Asynchronous reset in the middle of a count, then a quiet idle period.
        do_reset();
        repeat (5) pulse(0, 5, 5);
        tick(8);
        chk("pre_reset_q", 64'(q_NS), 64'd5);
        #2;
        rst = 1'b0;
        #1;
        chk("async_reset", 64'(dut_vec()), 64'd0);
        @(negedge clk);
        tick(2);
        rst = 1'b1;
        for (int i = 0; i < 100; i++) begin
            tick(1);
            chk("idle", 64'(dut_vec()), 64'd0);
        end

        // Debounce: short glitch rejected, exact latency, one event per held level.
        pulse(0, DEBOUNCE - 1, 12);
        tick(8);
        chk("glitch_q", 64'(q_NS), 64'd0);
        raw[0] = 1'b1;
        for (int k = 1; k <= LAT + 1; k++) begin
            tick(1);
            if (k == LAT) chk("lat_early_q", 64'(q_NS), 64'd0);
        end
        chk("lat_q", 64'(q_NS), 64'd1);
        chk("lat_s1", 64'(S1_NS), 64'd1);
        tick(3);
        raw[0] = 1'b0;
        tick(10);
        chk("one_event_q", 64'(q_NS), 64'd1);
        raw[0] = 1'b1;
        tick(40);
        chk("held_q", 64'(q_NS), 64'd2);
        raw[0] = 1'b0;
        tick(10);
        pulse(0, DEBOUNCE, 10);
        chk("min_pulse_q", 64'(q_NS), 64'd3);

        // Red-run on WE, then clear.
        do_reset();
        repeat (3) pulse(3, 5, 5);
        pulse(7, 5, 5);
        tick(8);
        chk("redrun_q", 64'(q_WE), 64'd3);
        chk("redrun_flag", 64'(red_run), 64'b1000);
        err_clr = 1'b1;
        tick(1);
        err_clr = 1'b0;
        chk("redrun_clr", 64'(red_run), 64'd0);
        chk("redrun_q_kept", 64'(q_WE), 64'd3);

        // Saturation on SN with minimum event spacing.
        do_reset();
        repeat (QMAX + 3) pulse(1, DEBOUNCE, DEBOUNCE);
        tick(8);
        chk("sat_q", 64'(q_SN), 64'(QMAX));
        chk("sat_ovf", 64'(ovf), 64'b0010);
        chk("sat_s5", 64'(S5_SN), 64'd1);
        err_clr = 1'b1;
        tick(1);
        err_clr = 1'b0;
        chk("sat_ovf_clr", 64'(ovf), 64'd0);

        // Simultaneous arrival and qualified departure at the top and at zero.
        light[1] = 2'b10;
        light[0] = 2'b10;
        raw[1] = 1'b1;
        raw[5] = 1'b1;
        tick(5);
        raw[1] = 1'b0;
        raw[5] = 1'b0;
        tick(10);
        chk("simul_max_q", 64'(q_SN), 64'(QMAX));
        chk("simul_max_flags", 64'({ovf, red_run}), 64'd0);
        raw[0] = 1'b1;
        raw[4] = 1'b1;
        tick(5);
        raw[0] = 1'b0;
        raw[4] = 1'b0;
        tick(10);
        chk("simul_zero_q", 64'(q_NS), 64'd0);
        chk("simul_zero_s1", 64'(S1_NS), 64'd0);
        chk("simul_zero_flags", 64'({ovf, red_run}), 64'd0);

        // Drain SN to zero, then departures on an empty queue.
        repeat (QMAX) pulse(5, DEBOUNCE, DEBOUNCE);
        tick(8);
        chk("drain_q", 64'(q_SN), 64'd0);
        chk("drain_s1s5", 64'({S1_SN, S5_SN}), 64'd0);
        repeat (2) pulse(5, DEBOUNCE, DEBOUNCE);
        tick(8);
        chk("underflow_q", 64'(q_SN), 64'd0);
        chk("underflow_flags", 64'({ovf, red_run}), 64'd0);

        // Randomized run against the reference model.
        do_reset();
        for (int c = 0; c < 8; c++) begin
            lvl[c] = 1'b0;
            seg_left[c] = DEBOUNCE;
            for (int t = 0; t < NCYC + 16; t++) ev[c][t] = 1'b0;
        end
        for (int l = 0; l < 4; l++) begin
            mq[l] = 0;
            ms1[l] = 1'b0;
            ms5[l] = 1'b0;
        end
        movf = '0;
        mred = '0;

        for (int cyc = 0; cyc < NCYC; cyc++) begin
            mvec = model_vec();
            chk("rand", 64'(dut_vec()), 64'(mvec));
            r = cyc + 1;
            for (int c = 0; c < 8; c++) begin
                if (seg_left[c] == 0) begin
                    if (!lvl[c]) begin
                        lvl[c] = 1'b1;
                        if ($urandom_range(0, 3) == 0) begin
                            seg_left[c] = $urandom_range(1, DEBOUNCE - 1);
                        end else begin
                            seg_left[c] = $urandom_range(DEBOUNCE, DEBOUNCE + 6);
                            ev[c][r + LAT] = 1'b1;
                        end
                    end else begin
                        lvl[c] = 1'b0;
                        if (c < 4) gmax = (cyc < NCYC / 2) ? DEBOUNCE + 6 : DEBOUNCE + 30;
                        else       gmax = (cyc < NCYC / 2) ? DEBOUNCE + 20 : DEBOUNCE + 4;
                        seg_left[c] = $urandom_range(DEBOUNCE, gmax);
                    end
                end
                raw[c] = lvl[c];
                seg_left[c]--;
            end
            for (int l = 0; l < 4; l++) light[l] = 2'($urandom_range(0, 3));
            err_clr = ($urandom_range(0, 15) == 0);

            ovf_set = '0;
            red_set = '0;
            for (int l = 0; l < 4; l++) begin
                a  = ev[l][r];
                d  = ev[4 + l][r];
                go = (light[l] == 2'd1) || (light[l] == 2'd2);
                if (d && !go) red_set[l] = 1'b1;
                if (a && !(d && go)) begin
                    if (mq[l] == QMAX) ovf_set[l] = 1'b1;
                    else mq[l] = mq[l] + 1;
                end else if (d && go && !a) begin
                    if (mq[l] > 0) mq[l] = mq[l] - 1;
                end
                ms1[l] = (mq[l] > 0);
                if (mq[l] >= CONG_THRESH) ms5[l] = 1'b1;
                else if (mq[l] < CONG_THRESH - HYST) ms5[l] = 1'b0;
            end
            movf = (err_clr ? 4'b0000 : movf) | ovf_set;
            mred = (err_clr ? 4'b0000 : mred) | red_set;
            tick(1);
        end
        mvec = model_vec();
        chk("rand_final", 64'(dut_vec()), 64'(mvec));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
